// File: rtl/axis_mac_neuron.sv
// Single-neuron fixed-point MAC: streams (weight, activation) pairs, adds a bias,
// and emits one saturated result per vector. Pipeline: product register, then accumulator.
module axis_mac_neuron #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]   bias,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

    state_t                        state_q;
    logic signed [PW-1:0]          prod_q;
    logic                          prod_vld_q;
    logic                          prod_first_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [DATA_WIDTH-1:0]  bias_q;
    logic                          first_q;
    logic [DATA_WIDTH-1:0]         tdata_q;
    logic                          tvalid_q;

    logic                          beat;
    logic signed [DATA_WIDTH-1:0]  weight;
    logic signed [DATA_WIDTH-1:0]  act;
    logic signed [PW-1:0]          prod_d;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]         sat_d;

    assign s_axis_tready = (state_q == ACCUM);
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign weight        = s_axis_tdata[PW-1:DATA_WIDTH];
    assign act           = s_axis_tdata[DATA_WIDTH-1:0];
    assign prod_d        = weight * act;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != ACCUM) | ~first_q;

    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    assign prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};

    // The first product of a vector restarts the sum from the bias, aligned to Q format.
    always_comb begin
        acc_d = acc_q;
        if (prod_vld_q) begin
            if (prod_first_q)
                acc_d = (bias_ext <<< FRAC_BITS) + prod_ext;
            else
                acc_d = acc_q + prod_ext;
        end
    end

    always_comb begin
        shifted = acc_q >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            sat_d = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat_d = SAT_MIN[DATA_WIDTH-1:0];
        else
            sat_d = shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            acc_q        <= '0;
            bias_q       <= '0;
            first_q      <= 1'b1;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
        end else begin
            prod_vld_q <= beat;
            acc_q      <= acc_d;
            if (beat) begin
                prod_q       <= prod_d;
                prod_first_q <= first_q;
            end
            if (beat && first_q) begin
                bias_q  <= bias;
                first_q <= 1'b0;
            end
            case (state_q)
                ACCUM: begin
                    if (beat && s_axis_tlast)
                        state_q <= DRAIN;
                end
                // No product in flight means the last beat has reached the accumulator.
                DRAIN: begin
                    if (!prod_vld_q) begin
                        state_q  <= OUT;
                        tdata_q  <= sat_d;
                        tvalid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (m_axis_tready) begin
                        state_q  <= ACCUM;
                        tvalid_q <= 1'b0;
                        first_q  <= 1'b1;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_mac_neuron.sv
// Scoreboard bench for axis_mac_neuron: driver pushes reference dot products,
// a negedge monitor pops and compares whenever a result is presented.
module tb_axis_mac_neuron;

    localparam int DW = 16;
    localparam int F  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] bias;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, busy;

    always #5 clk = ~clk;

    axis_mac_neuron #(.DATA_WIDTH(DW), .FRAC_BITS(F), .ACC_WIDTH(40)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .bias(bias),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy(busy)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] exp_q[$];
    bit  pending = 0;
    int  tl_cyc = 0;
    bit  rand_rdy = 0;
    int  wa[256];
    int  xa[256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, floor-divided by 2^F, then clamped.
    function automatic logic [DW-1:0] ref_model(input int b, input int n);
        longint s, r;
        s = longint'(b) * (longint'(1) << F);
        for (int i = 0; i < n; i++) s += longint'(wa[i]) * longint'(xa[i]);
        r = s >>> F;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[DW-1:0];
    endfunction

    task automatic drive_rdy();
        if (rand_rdy) m_tready = ($urandom_range(3) != 0);
    endtask

    // Entered and left at posedge+1; presents up to max_beats of an n-beat vector.
    task automatic send_vec(input int b, input int n, input int gap_pct, input int max_beats);
        int  i = 0;
        int  guard = 0;
        bit  take, take_last;
        while (i < max_beats && guard < 2000) begin
            guard++;
            drive_rdy();
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_tvalid = 1'b0;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = {wa[i][DW-1:0], xa[i][DW-1:0]};
                s_tlast  = (i == n - 1);
                bias     = b[DW-1:0];
            end
            @(negedge clk);
            take      = s_tvalid && s_tready;
            take_last = take && s_tlast;
            if (take_last) begin
                exp_q.push_back(ref_model(b, n));
                tl_cyc = cyc;
            end
            @(posedge clk);
            if (take_last) pending = 1;
            if (take) i++;
            #1;
        end
        if (guard >= 2000) chk("send_timeout", 64'(i), 64'(max_beats));
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (pending && guard < 200) begin
            drive_rdy();
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("result_timeout", 64'(pending), 64'(0));
    endtask

    task automatic fill(input int n, input int w, input int x);
        for (int i = 0; i < n; i++) begin wa[i] = w; xa[i] = x; end
    endtask

    // Monitor
    bit            vld_prev = 0, stall_prev = 0, hs_prev = 0;
    logic [DW-1:0] last_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            vld_prev = 0; stall_prev = 0; hs_prev = 0;
        end else begin
            if (hs_prev) begin
                chk("post_hs_s_tready", 64'(s_tready), 64'(1));
                chk("post_hs_m_tvalid", 64'(m_tvalid), 64'(0));
                hs_prev = 0;
            end
            if (pending) begin
                chk("pend_s_tready", 64'(s_tready), 64'(0));
                chk("pend_busy", 64'(busy), 64'(1));
            end
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(m_tdata), 64'(1) << 32);
                end else begin
                    if (!vld_prev) chk("latency", 64'(cyc - tl_cyc), 64'(3));
                    if (stall_prev) chk("stall_stable", 64'(m_tdata), 64'(last_data));
                    chk("result", 64'(m_tdata), 64'(exp_q[0]));
                    if (m_tready) begin
                        void'(exp_q.pop_front());
                        pending = 0;
                        hs_prev = 1;
                    end
                end
            end
            stall_prev = m_tvalid && !m_tready;
            last_data  = m_tdata;
            vld_prev   = m_tvalid && !m_tready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1; s_tvalid = 0; s_tdata = '0; s_tlast = 0; bias = '0; m_tready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(1));
        @(posedge clk); #1 rst = 0;

        fill(3, 16'h0100, 16'h0200);
        send_vec(0, 3, 0, 3); wait_done();
        chk("t1_model", 64'(ref_model(0, 3)), 64'h0600);

        fill(1, 16'h0100, -256);
        send_vec(16'h0080, 1, 0, 1); wait_done();
        fill(1, 1, -1);
        send_vec(0, 1, 0, 1); wait_done();

        fill(4, 16'h7FFF, 16'h7FFF);
        send_vec(0, 4, 0, 4); wait_done();
        fill(4, 16'h7FFF, -32768);
        send_vec(0, 4, 0, 4); wait_done();

        // Backpressure: hold result for five cycles
        m_tready = 0;
        fill(2, 16'h0300, -1000);
        send_vec(-5, 2, 0, 2);
        guard = 0;
        while (!m_tvalid && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("bp_tvalid_seen", 64'(m_tvalid), 64'(1));
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_busy", 64'(busy), 64'(1));
        m_tready = 1;
        wait_done();

        // Reset after two beats of a four-beat vector
        fill(4, 16'h0200, 16'h0300);
        send_vec(16'h0040, 4, 0, 2);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("mid_rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_s_tready", 64'(s_tready), 64'(1));
        @(posedge clk); #1 rst = 0;
        repeat (4) begin @(posedge clk); #1; end
        fill(1, 16'h0100, 16'h0100);
        send_vec(16'h0100, 1, 0, 1); wait_done();

        // Random back-to-back vectors with gaps and random downstream readiness
        rand_rdy = 1;
        for (int v = 0; v < 30; v++) begin
            int n, b;
            logic signed [DW-1:0] t;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                if (v % 2 == 0) begin
                    t = DW'($urandom); wa[i] = t;
                    t = DW'($urandom); xa[i] = t;
                end else begin
                    wa[i] = int'($urandom_range(1023)) - 512;
                    xa[i] = int'($urandom_range(1023)) - 512;
                end
            end
            t = DW'($urandom); b = t;
            send_vec(b, n, 20, n);
        end
        rand_rdy = 0;
        m_tready = 1;
        wait_done();
        repeat (3) begin @(posedge clk); #1; end

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axis_mac_neuron.md
Name: axis_mac_neuron

Overview:
- Single-neuron multiply-accumulate stage. Consumes an AXI-Stream vector of signed (weight, activation) pairs and accumulates their fixed-point dot product plus a bias.
- Emits one saturated signed DATA_WIDTH result per vector on an AXI-Stream master.
- Sits directly upstream of the enable/clear activation register and drives its d/en inputs.

Parameters:
- DATA_WIDTH, 16, signed width of weight, activation, bias and result.
- FRAC_BITS, 8, fractional bits of the fixed-point format (Q7.8 at defaults).
- ACC_WIDTH, 40, signed accumulator width. Must be ≥ 2*DATA_WIDTH + 8, which gives exact results for vectors of up to 256 beats.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  2*DATA_WIDTH  {weight[2*DW-1:DW], activation[DW-1:0]}, both signed.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid & tready.
- s_axis_tlast  in  1  marks the last beat of a vector.
- bias  in  DATA_WIDTH  signed bias, sampled on the first beat of each vector.
- m_axis_tdata  out  DATA_WIDTH  signed saturated neuron result.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accepts the result.
- busy  out  1  high from the first accepted beat until the result handshake completes.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- Reset, with rst high at a rising edge:
  - Registered outputs: m_axis_tvalid=0, m_axis_tdata=0, busy=0.
  - State returns to ACCUM; accumulator, product register, pipeline valid bits and first-beat flag are cleared.
  - s_axis_tready follows the state, so it is 1 from the first cycle after the reset edge.
  - Reset mid-vector discards the partial vector; no result is emitted for it.
- FSM states: ACCUM, DRAIN, OUT.
  - ACCUM: s_axis_tready=1. An accepted beat with tlast=1 moves the FSM to DRAIN.
  - DRAIN: s_axis_tready=0. Waits until the pipeline holding the last beat has written the accumulator, then moves to OUT.
  - OUT: s_axis_tready=0 and m_axis_tvalid=1. When m_axis_tvalid & m_axis_tready, the FSM returns to ACCUM and m_axis_tvalid drops next cycle.
- Pipeline (two stages):
  - Stage 1: registered product p = weight*activation, 2*DATA_WIDTH signed, exact, with a valid bit.
  - Stage 2: accumulator update.
    - First product of a vector: acc = sext(bias)<<FRAC_BITS + sext(p).
    - Otherwise: acc = acc + sext(p).
    - The accumulator wraps two's-complement modulo 2^ACC_WIDTH; there is no saturation inside the accumulator.
- First-beat flag: set by reset and by each output handshake; cleared by the first accepted beat. bias is captured into a register on that beat.
- Output conversion:
  - r = acc >>> FRAC_BITS, arithmetic shift, truncating toward -inf.
  - r is saturated to [-2^(DW-1), 2^(DW-1)-1] and loaded into m_axis_tdata on the DRAIN→OUT transition.
- Latency: if the tlast beat is accepted in cycle n, m_axis_tvalid=1 and the result are valid in cycle n+3. Throughput is one beat per cycle within a vector.
- Backpressure: m_axis_tdata and m_axis_tvalid stay stable while m_axis_tready=0, and s_axis_tready stays 0. The earliest next-vector beat is accepted in the cycle after the output handshake.
- Single-beat vector (tlast on the first beat): valid case; result = bias + product.
- s_axis_tvalid gaps inside a vector: allowed; the accumulator holds its value.
- busy = (state != ACCUM) | (first-beat flag == 0).

Test Plan:
- bias=0; three beats w=0x0100, x=0x0200, tlast on beat 3, m_axis_tready=1 → m_axis_tdata=0x0600 with tvalid exactly 3 cycles after the tlast acceptance cycle. s_axis_tready=0 from the cycle after tlast through the handshake.
- Single beat bias=0x0080, w=0x0100, x=0xFF00 → 0xFF80 (−0.5). Next vector: bias=0, w=0x0001, x=0xFFFF → 0xFFFF (truncation toward −inf).
- Four beats w=x=0x7FFF → 0x7FFF (positive saturation). Four beats w=0x7FFF, x=0x8000 → 0x8000 (negative saturation).
- Result pending with m_axis_tready=0 for 5 cycles → m_axis_tdata/tvalid stable, s_axis_tready=0, busy=1. Raise tready → handshake in one cycle, s_axis_tready=1 next cycle.
- Assert rst for one cycle after 2 beats of a 4-beat vector → m_axis_tvalid=0, tdata=0, busy=0, no result emitted. A following vector bias=0x0100, w=0x0100, x=0x0100 → 0x0200.
- Back-to-back vectors with s_axis_tvalid held high and random single-cycle tvalid gaps → each result matches a reference dot-product model.
